// File: rtl/regfifo_shift_param_pkg.sv
// Shared FIFO definitions: constant clog2 helper and status bit positions for CSR readback.
package fifo_defs;

    localparam int STAT_EMPTY  = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_AEMPTY = 2;
    localparam int STAT_AFULL  = 3;
    localparam int STAT_OVF    = 4;
    localparam int STAT_UDF    = 5;
    localparam int STAT_W      = 6;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfifo_shift_param_slot.sv
// One FIFO entry plus its valid bit. Load of din beats a shift from the slot above.
module regfifo_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_din,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] next_data,
    input  logic             next_valid,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_din) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end else if (shift_in) begin
            data_q  <= next_data;
            valid_q <= next_valid;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/regfifo_shift_param.sv
// Register-built first-word-fall-through shift FIFO; head entry is always slot 0.
module regfifo_shift_param
    import fifo_defs::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             din,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   data_count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0] valid_map;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    wr_idx;
    logic             overflow_q, underflow_q;
    logic             do_rd, do_wr;

    // Thermometer bitmap: slot 0 valid means non-empty, top slot valid means full.
    assign empty = !valid_map[0];
    assign full  = valid_map[DEPTH-1];
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // When popping in the same cycle, everything moves down one so din lands one slot lower.
    assign wr_idx = do_rd ? (count_q - CW'(1)) : count_q;

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [WIDTH-1:0] above_data;
        logic             above_valid;
        if (g == DEPTH - 1) begin : g_top
            assign above_data  = '0;
            assign above_valid = 1'b0;
        end else begin : g_mid
            assign above_data  = slot_data[g+1];
            assign above_valid = valid_map[g+1];
        end
        regfifo_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (flush),
            .load_din   (do_wr && (wr_idx == CW'(g))),
            .shift_in   (do_rd),
            .din        (din),
            .next_data  (above_data),
            .next_valid (above_valid),
            .data_o     (slot_data[g]),
            .valid_o    (valid_map[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_en && full && !rd_en) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign dout         = slot_data[0];
    assign data_count   = count_q;
    assign almost_full  = (count_q >= CW'(AFULL_TH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
